inst_fetch_responder: RTL and testbench
=======================================

# inst_fetch_responder

Responder for the core's instruction fetch port: answers the core's `inst_addr` requests with `instruction` and `inst_ready`. It fetches 32-bit words over a 16-bit external request/acknowledge memory bus, two halfword beats per word. A two-entry word buffer gives zero-wait hits, and a sequential prefetch of the next word hides bus latency for straight-line code.

## Interface
- `RESET_INSTR`, default `32'h0000_0013`: value driven on `instruction` when no buffer entry hits (NOP).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `inst_addr`  in  32  fetch byte address from the core, sampled every edge; bits [1:0] are ignored (word-aligned).
- `instruction`  out  32  word for the address sampled at the previous edge; `RESET_INSTR` when `inst_ready` is 0.
- `inst_ready`  out  1  1 when `instruction` is valid for the previously sampled address.
- `flush`  in  1  synchronous; invalidates both buffer entries.
- `ext_req`  out  1  external beat request; held until `ext_ack`.
- `ext_addr`  out  32  halfword byte address (bit 0 = 0); stable while `ext_req` is 1.
- `ext_ack`  in  1  one-cycle beat acknowledge; may occur in the same cycle `ext_req` rises.
- `ext_rdata`  in  16  beat data, valid when `ext_ack` is 1.

## Operation
- `req_addr <= {inst_addr[31:2], 2'b00}` on every edge.
- Buffer entries E0 and E1 each hold `valid`, `addr[31:2]` and `data[31:0]`.
- A hit is `valid && addr == req_addr[31:2]`.
- `inst_ready` = hit in E0 or E1. `instruction` = data of the hitting entry. Both are combinational from registers.
- Fetch FSM states: `IDLE`, `LO`, `HI`.
- Target selection in `IDLE`:
  - If `req_addr` misses both entries, the target is the demand word `req_addr`.
  - Else, if neither entry holds `req_addr+4`, the target is the prefetch word `req_addr+4`.
  - Else, stay in `IDLE`.
  - Victim entry: the one not hit by `req_addr`. If neither hits, the victim is the one named by a replace pointer, which toggles on every fill.
  - On leaving `IDLE`, latch `tgt_addr` and `victim`, and clear the victim's `valid`.
- `LO`: `ext_req=1`, `ext_addr=tgt_addr`. On `ext_ack`, latch `lo <= ext_rdata` and go to `HI`.
- `HI`: `ext_req=1`, `ext_addr=tgt_addr+2`. On `ext_ack`, write the victim entry (`valid=1`, `addr`, `data={ext_rdata, lo}`, little-endian) and go to `IDLE`.
- Redirect happens only at a beat boundary, never mid-beat; `ext_req`/`ext_addr` must not change before `ack`.
  - Condition: on `ext_ack` in `LO` or `HI`, `tgt_addr` is neither `req_addr` nor `req_addr+4`, and `req_addr` misses.
  - Action: discard the word without writing the entry, and go to `IDLE`.
- Address arithmetic is 32-bit modulo; `32'hFFFF_FFFC + 4` wraps to `0`.
- `flush`:
  - Clears both `valid` bits that cycle.
  - If the FSM is in `LO` or `HI`, the current beat completes and the fill is discarded.
  - `flush` takes priority over a fill write in the same cycle.

## Timing
- Reset values: `inst_ready=0`, `instruction=RESET_INSTR`, `ext_req=0`, `ext_addr=0`, FSM=`IDLE`, both `valid=0`, replace pointer = E0, `req_addr=0`.
- Reset mid-transaction abandons the beat immediately, with `ext_req=0` the next cycle; the external side must tolerate a dropped request.
- Hit: `inst_ready=1` in the cycle after `inst_addr` is sampled (zero wait).
- Demand miss with zero-wait memory, from sample edge E:
  - E+1: FSM `IDLE`→`LO`.
  - E+2: `LO` beat acked.
  - E+3: `HI` beat acked, entry written.
  - Cycle after E+3: `inst_ready=1`.
  - Total: 3 wait cycles; each external wait state adds 1.
- Prefetch starts in the cycle after a demand fill completes. Sequential code at full bus speed then sees 0 wait after the first miss, as long as the core consumes at most one word per 3 cycles; otherwise it sees partial waits.
- The core holds `inst_addr` while `inst_ready=0`. Any change while waiting is handled by the redirect rule.

## Structure
- Shared `types` package:
  - `fetch_state_t` enum (`IDLE`, `LO`, `HI`).
  - The existing `NOP` constant, used as the `RESET_INSTR` default.
- Sub-module `fetch_word_buffer`:
  - Two entries, hit compare, output mux, victim selection, replace pointer, flush.
  - The top level keeps the FSM, `req_addr` register and external bus drive.

## Test plan
- Reset, then `inst_addr=0x100`, memory `0x100=0x1234`, `0x102=0xABCD`, zero-wait → `ext_addr` sequence `0x100`, `0x102`; `inst_ready` rises 3 cycles after sampling with `instruction=0xABCD1234`; `ext_addr=0x104` prefetch follows immediately.
- Sequential `0x100`, `0x104`, `0x108` with the core advancing on `inst_ready` → `0x104` hits with 0 wait after its prefetch completes; `0x108` prefetch issued; no `ext_addr` repeats an already-valid word.
- `ext_ack` delayed 2 cycles per beat → `ext_req` and `ext_addr` held stable throughout; miss latency 7 cycles; data correct.
- Redirect: request `0x200` miss, then `inst_addr` changes to `0x800` during the `LO` beat → `0x200` beat completes, no entry written for `0x200`, next `ext_addr=0x800`, `inst_ready` only for `0x800`.
- `flush` while both entries are valid and `0x104` is hitting → `inst_ready=0` the next cycle; `0x104` refetched; `flush` concurrent with the `HI` ack leaves the entry invalid.
- `rst_n=0` asserted during the `HI` beat → next cycle `ext_req=0`, `inst_ready=0`, `instruction=0x00000013`; after release, `inst_addr=0xFFFFFFFC` fetch, then prefetch `ext_addr=0x00000000` (wrap).

Source files
------------

// File: rtl/inst_fetch_responder_pkg.sv
// Shared types for the instruction fetch responder.
package inst_fetch_responder_pkg;

    // Existing no-op encoding (addi x0, x0, 0) driven when nothing is valid.
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StLo,
        StHi
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_responder_word_buffer.sv
// Two-entry instruction word buffer: hit compare, output mux, victim choice, flush.
module fetch_word_buffer
    import inst_fetch_responder_pkg::*;
#(
    parameter logic [31:0] MissData = NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic [29:0] req_word_i,
    input  logic [29:0] next_word_i,
    output logic        req_hit_o,
    output logic        next_hit_o,
    output logic [31:0] hit_data_o,
    output logic        victim_o,
    input  logic        inval_i,
    input  logic        inval_idx_i,
    input  logic        fill_i,
    input  logic        fill_idx_i,
    input  logic [29:0] fill_word_i,
    input  logic [31:0] fill_data_i
);

    logic [1:0]  valid_q, valid_d;
    logic [29:0] addr_q [2];
    logic [29:0] addr_d [2];
    logic [31:0] data_q [2];
    logic [31:0] data_d [2];
    logic        rptr_q, rptr_d;
    logic [1:0]  hit;
    logic [1:0]  next_hit;

    // Tag compare against the demand word and the sequential successor.
    always_comb begin
        hit[0]      = valid_q[0] && (addr_q[0] == req_word_i);
        hit[1]      = valid_q[1] && (addr_q[1] == req_word_i);
        next_hit[0] = valid_q[0] && (addr_q[0] == next_word_i);
        next_hit[1] = valid_q[1] && (addr_q[1] == next_word_i);
    end

    assign req_hit_o  = |hit;
    assign next_hit_o = |next_hit;

    // Output mux and victim selection; victim is the entry the core is not using.
    always_comb begin
        hit_data_o = MissData;
        if (hit[0]) begin
            hit_data_o = data_q[0];
        end else if (hit[1]) begin
            hit_data_o = data_q[1];
        end
        if (hit[0]) begin
            victim_o = 1'b1;
        end else if (hit[1]) begin
            victim_o = 1'b0;
        end else begin
            victim_o = rptr_q;
        end
    end

    // Entry update; flush overrides any fill landing in the same cycle.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rptr_d  = rptr_q;
        if (inval_i) begin
            valid_d[inval_idx_i] = 1'b0;
        end
        if (fill_i) begin
            valid_d[fill_idx_i] = 1'b1;
            addr_d[fill_idx_i]  = fill_word_i;
            data_d[fill_idx_i]  = fill_data_i;
            rptr_d              = ~rptr_q;
        end
        if (flush_i) begin
            valid_d = 2'b00;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 2'b00;
            rptr_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rptr_q  <= rptr_d;
        end
    end

    // Tag and data storage; qualified by valid so no reset needed.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: buffers two words, fetches over a 16-bit req/ack bus.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_addr,
    output logic [31:0] instruction,
    output logic        inst_ready,
    input  logic        flush,
    output logic        ext_req,
    output logic [31:0] ext_addr,
    input  logic        ext_ack,
    input  logic [15:0] ext_rdata
);

    fetch_state_t state_q, state_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [29:0]  tgt_q, tgt_d;
    logic         victim_q, victim_d;
    logic [15:0]  lo_q, lo_d;
    logic         abort_q, abort_d;

    logic [29:0]  req_word;
    logic [29:0]  next_word;
    logic         req_hit;
    logic         next_hit;
    logic         victim;
    logic         inval_en;
    logic         fill_en;
    logic         redirect;
    logic         discard;
    logic         unused_addr_lsbs;

    assign req_addr_d       = {inst_addr[31:2], 2'b00};
    assign req_word         = req_addr_q[31:2];
    assign next_word        = req_word + 30'd1;  // wraps modulo 2^32 bytes
    assign unused_addr_lsbs = ^{inst_addr[1:0], req_addr_q[1:0]};

    fetch_word_buffer #(
        .MissData (RESET_INSTR)
    ) u_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .req_word_i  (req_word),
        .next_word_i (next_word),
        .req_hit_o   (req_hit),
        .next_hit_o  (next_hit),
        .hit_data_o  (instruction),
        .victim_o    (victim),
        .inval_i     (inval_en),
        .inval_idx_i (victim),
        .fill_i      (fill_en),
        .fill_idx_i  (victim_q),
        .fill_word_i (tgt_q),
        .fill_data_i ({ext_rdata, lo_q})
    );

    assign inst_ready = req_hit;

    // The core moved elsewhere: the in-flight word is neither wanted nor a useful prefetch.
    assign redirect = (tgt_q != req_word) && (tgt_q != next_word) && !req_hit;
    assign discard  = abort_q || flush || redirect;

    // Fetch FSM: pick demand or prefetch target, then run the two halfword beats.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        victim_d = victim_q;
        lo_d     = lo_q;
        abort_d  = abort_q;
        ext_req  = 1'b0;
        ext_addr = 32'h0;
        inval_en = 1'b0;
        fill_en  = 1'b0;
        case (state_q)
            StIdle: begin
                abort_d = 1'b0;
                if (!flush && (!req_hit || !next_hit)) begin
                    tgt_d    = req_hit ? next_word : req_word;
                    victim_d = victim;
                    inval_en = 1'b1;
                    state_d  = StLo;
                end
            end
            StLo: begin
                ext_req  = 1'b1;
                ext_addr = {tgt_q, 2'b00};
                if (flush) begin
                    abort_d = 1'b1;
                end
                if (ext_ack) begin
                    lo_d    = ext_rdata;
                    state_d = discard ? StIdle : StHi;
                end
            end
            StHi: begin
                ext_req  = 1'b1;
                ext_addr = {tgt_q, 2'b10};
                if (flush) begin
                    abort_d = 1'b1;
                end
                if (ext_ack) begin
                    fill_en = !discard;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset drops any beat in flight immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_addr_q <= 32'h0;
            tgt_q      <= 30'h0;
            victim_q   <= 1'b0;
            lo_q       <= 16'h0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            tgt_q      <= tgt_d;
            victim_q   <= victim_d;
            lo_q       <= lo_d;
            abort_q    <= abort_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder with a halfword memory model and scoreboard.
module tb_inst_fetch_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_addr;
    logic [31:0] instruction;
    logic        inst_ready;
    logic        flush;
    logic        ext_req;
    logic [31:0] ext_addr;
    logic        ext_ack;
    logic [15:0] ext_rdata;

    int          ack_delay = 0;
    int          wcnt = 0;
    int          viol = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] sb[$];
    logic [31:0] ack_log[$];

    always #5 clk = ~clk;

    inst_fetch_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_addr   (inst_addr),
        .instruction (instruction),
        .inst_ready  (inst_ready),
        .flush       (flush),
        .ext_req     (ext_req),
        .ext_addr    (ext_addr),
        .ext_ack     (ext_ack),
        .ext_rdata   (ext_rdata)
    );

    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        if (a == 32'h100) return 16'h1234;
        if (a == 32'h102) return 16'hABCD;
        return a[15:0] ^ a[31:16] ^ 16'h5A5A;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return {mem_rd(w + 32'd2), mem_rd(w)};
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < ack_log.size()) return ack_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Memory responder: ack after ack_delay wait cycles, combinational data.
    assign ext_ack   = ext_req && (wcnt >= ack_delay);
    assign ext_rdata = ext_ack ? mem_rd(ext_addr) : 16'hDEAD;

    always @(posedge clk) begin
        wcnt <= (ext_req && !ext_ack) ? wcnt + 1 : 0;
        if (ext_req && ext_ack) ack_log.push_back(ext_addr);
    end

    // Request must hold with a stable address until acked (reset may drop it).
    always @(negedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else begin
            if (pend && (ext_req !== 1'b1 || ext_addr !== pend_addr)) viol <= viol + 1;
            pend      <= ext_req && !ext_ack;
            pend_addr <= ext_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a);
        inst_addr = a;
        sb.push_back(exp_word(a));
    endtask

    task automatic wait_ready(input string tag, output int waits);
        logic [31:0] exp;
        bit          got;
        got   = 1'b0;
        waits = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (inst_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            waits++;
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        if (got) check(tag, instruction, exp);
        else check({tag, "_timeout"}, {31'd0, inst_ready}, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] a, input string tag, output int waits);
        drive(a);
        wait_ready(tag, waits);
    endtask

    task automatic settle();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 60 && quiet < 3; i++) begin
            step(1);
            if (ext_req === 1'b0) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) check("settle_timeout", {31'd0, ext_req}, 32'd0);
    endtask

    initial begin
        int w;
        int dups;
        rst_n     = 1'b0;
        flush     = 1'b0;
        inst_addr = 32'h0;
        step(2);
        check("rst_ready", {31'd0, inst_ready}, 32'd0);
        check("rst_instr", instruction, 32'h0000_0013);
        check("rst_req", {31'd0, ext_req}, 32'd0);
        check("rst_ext_addr", ext_addr, 32'h0);

        // Start from the reset vector, then go to 0x100.
        rst_n = 1'b1;
        fetch(32'h0, "boot_0", w);
        settle();
        ack_log.delete();
        fetch(32'h100, "miss_100", w);
        check("miss_100_waits", 32'(w), 32'd3);
        check("miss_100_word", instruction, 32'hABCD_1234);
        check("miss_100_lo", log_at(0), 32'h100);
        check("miss_100_hi", log_at(1), 32'h102);
        step(1);
        check("pf_104_req", {31'd0, ext_req}, 32'd1);
        check("pf_104_addr", ext_addr, 32'h104);

        // Slow sequential core: prefetched words hit with zero wait.
        step(2);
        fetch(32'h104, "seq_104", w);
        check("seq_104_waits", 32'(w), 32'd0);
        step(3);
        fetch(32'h108, "seq_108", w);
        check("seq_108_waits", 32'(w), 32'd0);
        dups = 0;
        for (int i = 0; i < ack_log.size(); i++)
            for (int j = i + 1; j < ack_log.size(); j++)
                if (ack_log[i] == ack_log[j]) dups++;
        check("no_refetch", 32'(dups), 32'd0);

        // Two wait states per beat.
        settle();
        ack_delay = 2;
        fetch(32'h300, "slow_300", w);
        check("slow_300_waits", 32'(w), 32'd7);
        check("slow_stable", 32'(viol), 32'd0);

        // Redirect during the LO beat.
        settle();
        ack_log.delete();
        inst_addr = 32'h200;
        step(2);
        check("redir_lo_addr", ext_addr, 32'h200);
        fetch(32'h800, "redir_800", w);
        check("redir_log0", log_at(0), 32'h200);
        check("redir_log1", log_at(1), 32'h800);
        check("redir_log2", log_at(2), 32'h802);

        // Flush with both entries valid.
        ack_delay = 0;
        settle();
        fetch(32'h104, "pre_flush_104", w);
        step(3);
        ack_log.delete();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("flush_ready", {31'd0, inst_ready}, 32'd0);
        check("flush_instr", instruction, 32'h0000_0013);
        sb.push_back(exp_word(32'h104));
        wait_ready("refetch_104", w);
        check("refetch_log", log_at(0), 32'h104);

        // Flush coincident with the HI ack of the 0x108 prefetch.
        step(2);
        check("pf_hi_addr", ext_addr, 32'h10A);
        flush = 1'b1;
        drive(32'h108);
        step(1);
        flush = 1'b0;
        check("flush_hi_nowrite", {31'd0, inst_ready}, 32'd0);
        wait_ready("after_flush_108", w);

        // Reset in the middle of a HI beat, then wrap-around prefetch.
        settle();
        ack_delay = 2;
        inst_addr = 32'h400;
        step(5);
        check("rst_mid_hi_addr", ext_addr, 32'h402);
        rst_n = 1'b0;
        step(1);
        check("rst_mid_req", {31'd0, ext_req}, 32'd0);
        check("rst_mid_ready", {31'd0, inst_ready}, 32'd0);
        check("rst_mid_instr", instruction, 32'h0000_0013);
        ack_delay = 0;
        inst_addr = 32'h0;
        rst_n = 1'b1;
        fetch(32'h0, "reboot_0", w);
        settle();
        fetch(32'hFFFF_FFFC, "top_word", w);
        check("top_word_waits", 32'(w), 32'd3);
        step(1);
        check("wrap_pf_req", {31'd0, ext_req}, 32'd1);
        check("wrap_pf_addr", ext_addr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
